pga_pot_writer: RTL
===================

PGA_POT_WRITER -- requirements
Module: pga_pot_writer

Interface
REQ-001 Parameter CLK_DIV, default 4: system clocks per SCLK half-period; legal range 1..255.
REQ-002 Parameter SETTLE_CYCLES, default 64: clocks of wait after each update before completion; legal range 1..65535.
REQ-003 Parameter POT_CMD, default 8'h11: command byte sent ahead of the pot code (write wiper 0).
REQ-004 Port: clk_i  input  1  system clock; all logic on the rising edge.
REQ-005 Port: rst_ni  input  1  asynchronous, active-low reset.
REQ-006 Port: pga_code_i  input  8  requested digital-pot code from the gain lookup.
REQ-007 Port: hga_active_i  input  1  requested HGA state from the gain lookup; 1 = HGA in path.
REQ-008 Port: update_i  input  1  single-cycle request to apply pga_code_i and hga_active_i.
REQ-009 Port: sclk_o  output  1  SPI clock, mode 0, idles low.
REQ-010 Port: mosi_o  output  1  SPI data, MSB first.
REQ-011 Port: cs_n_o  output  1  SPI chip select, active low.
REQ-012 Port: hga_en_o  output  1  HGA enable; 0 = HGA bypassed.
REQ-013 Port: busy_o  output  1  high from acceptance of a request until done_o.
REQ-014 Port: done_o  output  1  single-cycle pulse when an update completes.

Function
REQ-015 The block SHALL use the states IDLE, HGA_OFF, CS_SETUP, SHIFT, CS_HOLD, HGA_ON, SETTLE and DONE.
REQ-016 In IDLE, update_i SHALL latch pga_code_i and hga_active_i into the target registers and set busy_o on the next cycle.
REQ-017 If the target equals the last-written code and the current hga_en_o, the block SHALL go IDLE->DONE with no SPI frame; done_o SHALL pulse 2 cycles after update_i.
REQ-018 HGA_OFF, when the target HGA is 0 and hga_en_o is 1, SHALL clear hga_en_o for 1 cycle before CS_SETUP; otherwise HGA_OFF is skipped.
REQ-019 If only the HGA state changes, the SPI frame SHALL still be sent.
REQ-020 CS_SETUP SHALL drive cs_n_o low with sclk_o low and mosi_o = bit 15 for CLK_DIV cycles.
REQ-021 SHIFT SHALL send the 16-bit frame {POT_CMD, target code} MSB first.
REQ-022 Each bit in SHIFT SHALL hold sclk_o low for CLK_DIV cycles, then high for CLK_DIV cycles.
REQ-023 mosi_o SHALL change only on the falling edge of sclk_o (sclk_o going low); exactly 16 rising edges SHALL occur per frame.
REQ-024 CS_HOLD SHALL keep cs_n_o low and sclk_o low for CLK_DIV cycles, then raise cs_n_o.
REQ-025 On leaving CS_HOLD, the last-written code register SHALL be set to the target code.
REQ-026 HGA_ON, when the target HGA is 1, SHALL set hga_en_o 1 cycle after cs_n_o rises; the pot is always written before the HGA is enabled.
REQ-027 SETTLE SHALL count SETTLE_CYCLES clocks with cs_n_o high; DONE SHALL pulse done_o for 1 cycle, clear busy_o and return to IDLE.
REQ-028 update_i while busy_o is 1 SHALL overwrite a one-deep pending slot holding the latest inputs.
REQ-029 A pending request SHALL be accepted in the cycle after DONE as if update_i had been asserted in IDLE.
REQ-030 update_i in the same cycle as DONE SHALL go to the pending slot.
REQ-031 After reset the last-written code SHALL be invalid, so the first update always sends a frame.

Reset
REQ-032 While rst_ni is low: cs_n_o=1, sclk_o=0, mosi_o=0, hga_en_o=0, busy_o=0, done_o=0, state=IDLE, pending slot empty, last-written code invalid.
REQ-033 Reset asserted mid-frame SHALL abort the frame immediately with the values of REQ-032; after release, no frame resumes until a new update_i.

Verification
REQ-034 Reset release, then update_i with code 8'h80 and HGA 0, CLK_DIV=4 -> one frame of 16'h1180; 16 SCLK rises 8 clocks apart; hga_en_o stays 0; done_o pulses once.
REQ-035 From the 8'h80/HGA 0 state, update_i with 8'h80 and HGA 1 -> frame 16'h1180 sent, then hga_en_o rises 1 cycle after cs_n_o rises; done_o pulses after SETTLE_CYCLES.
REQ-036 From 8'h80/HGA 1, update_i with 8'hDC and HGA 0 -> hga_en_o falls before cs_n_o falls; frame 16'h11DC sent.
REQ-037 Repeat the last update (8'hDC, HGA 0) -> no cs_n_o activity; done_o pulses 2 cycles after update_i.
REQ-038 During a frame, update_i with 8'h99 then 8'hA5 -> the current frame completes, then exactly one further frame 16'h11A5 is sent.
REQ-039 rst_ni low at SHIFT bit 7 -> cs_n_o=1 and sclk_o=0 at once; no activity after release until update_i.

Source files
------------

// File: rtl/pga_pot_writer.sv
// -----------------------------------------------------------------------------
// pga_pot_writer
//
// Applies a gain setting to the analog front end: writes the requested code
// into an SPI digital potentiometer (mode 0, 16-bit frame {POT_CMD, code},
// MSB first) and sequences the high-gain amplifier (HGA) enable so the pot is
// always written before the HGA is switched into the path, and the HGA is
// bypassed before a pot write that removes it. After each update the block
// waits SETTLE_CYCLES clocks and then pulses done_o.
//
// Requests arriving while busy go into a one-deep pending slot (latest wins).
// A request matching the last written code and current HGA state completes
// without an SPI frame.
//
// Parameters:
//   CLK_DIV        system clocks per SCLK half-period (1..255)
//   SETTLE_CYCLES  settle wait after each update (1..65535)
//   POT_CMD        command byte sent ahead of the pot code
// Ports:
//   clk_i          system clock
//   rst_ni         asynchronous active-low reset
//   pga_code_i     requested pot code
//   hga_active_i   requested HGA state (1 = HGA in path)
//   update_i       single-cycle request strobe
//   sclk_o         SPI clock, idles low
//   mosi_o         SPI data, MSB first
//   cs_n_o         SPI chip select, active low
//   hga_en_o       HGA enable (0 = bypassed)
//   busy_o         update in progress
//   done_o         single-cycle completion pulse
// -----------------------------------------------------------------------------
module pga_pot_writer #(
    parameter int unsigned CLK_DIV       = 4,
    parameter int unsigned SETTLE_CYCLES = 64,
    parameter logic [7:0]  POT_CMD       = 8'h11
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] pga_code_i,
    input  logic       hga_active_i,
    input  logic       update_i,
    output logic       sclk_o,
    output logic       mosi_o,
    output logic       cs_n_o,
    output logic       hga_en_o,
    output logic       busy_o,
    output logic       done_o
);

    typedef enum logic [2:0] {
        StIdle,
        StHgaOff,
        StCsSetup,
        StShift,
        StCsHold,
        StHgaOn,
        StSettle,
        StDone
    } state_e;

    localparam logic [15:0] DivLast    = 16'(CLK_DIV - 1);
    localparam logic [15:0] SettleLast = 16'(SETTLE_CYCLES - 1);

    state_e      state_q;
    logic [15:0] cnt_q;
    logic [15:0] shift_q;
    logic [3:0]  bit_q;
    logic [7:0]  tgt_code_q;
    logic        tgt_hga_q;
    logic [7:0]  last_code_q;
    logic        last_valid_q;
    logic [7:0]  pend_code_q;
    logic        pend_hga_q;
    logic        pend_valid_q;
    logic        sclk_q;
    logic        cs_n_q;
    logic        hga_en_q;
    logic        busy_q;
    logic        done_q;

    // Request source in IDLE: a fresh strobe is newer than anything pending.
    logic       req_go;
    logic [7:0] req_code;
    logic       req_hga;
    logic       req_same;

    always_comb begin
        req_go   = update_i | pend_valid_q;
        req_code = update_i ? pga_code_i : pend_code_q;
        req_hga  = update_i ? hga_active_i : pend_hga_q;
        req_same = last_valid_q && (req_code == last_code_q) && (req_hga == hga_en_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            shift_q      <= '0;
            bit_q        <= '0;
            tgt_code_q   <= '0;
            tgt_hga_q    <= 1'b0;
            last_code_q  <= '0;
            last_valid_q <= 1'b0;
            pend_code_q  <= '0;
            pend_hga_q   <= 1'b0;
            pend_valid_q <= 1'b0;
            sclk_q       <= 1'b0;
            cs_n_q       <= 1'b1;
            hga_en_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;

            // Any strobe outside IDLE (including the DONE cycle) parks in the slot.
            if (update_i && (state_q != StIdle)) begin
                pend_code_q  <= pga_code_i;
                pend_hga_q   <= hga_active_i;
                pend_valid_q <= 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (req_go) begin
                        tgt_code_q   <= req_code;
                        tgt_hga_q    <= req_hga;
                        busy_q       <= 1'b1;
                        pend_valid_q <= 1'b0;
                        cnt_q        <= '0;
                        if (req_same) begin
                            state_q <= StDone;
                        end else begin
                            shift_q <= {POT_CMD, req_code};
                            bit_q   <= 4'd15;
                            if (!req_hga && hga_en_q) begin
                                // Bypass the HGA before touching the pot.
                                hga_en_q <= 1'b0;
                                state_q  <= StHgaOff;
                            end else begin
                                cs_n_q  <= 1'b0;
                                state_q <= StCsSetup;
                            end
                        end
                    end
                end

                StHgaOff: begin
                    cs_n_q  <= 1'b0;
                    state_q <= StCsSetup;
                end

                StCsSetup: begin
                    if (cnt_q == DivLast) begin
                        cnt_q   <= '0;
                        state_q <= StShift;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

                StShift: begin
                    if (cnt_q != DivLast) begin
                        cnt_q <= cnt_q + 16'd1;
                    end else begin
                        cnt_q <= '0;
                        if (!sclk_q) begin
                            sclk_q <= 1'b1;
                        end else begin
                            // Falling edge: the only point where mosi may advance.
                            sclk_q <= 1'b0;
                            if (bit_q == 4'd0) begin
                                state_q <= StCsHold;
                            end else begin
                                bit_q   <= bit_q - 4'd1;
                                shift_q <= {shift_q[14:0], 1'b0};
                            end
                        end
                    end
                end

                StCsHold: begin
                    if (cnt_q == DivLast) begin
                        cnt_q        <= '0;
                        cs_n_q       <= 1'b1;
                        last_code_q  <= tgt_code_q;
                        last_valid_q <= 1'b1;
                        state_q      <= tgt_hga_q ? StHgaOn : StSettle;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

                StHgaOn: begin
                    hga_en_q <= 1'b1;
                    cnt_q    <= '0;
                    state_q  <= StSettle;
                end

                StSettle: begin
                    if (cnt_q == SettleLast) begin
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

                StDone: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign sclk_o   = sclk_q;
    assign mosi_o   = shift_q[15];
    assign cs_n_o   = cs_n_q;
    assign hga_en_o = hga_en_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;

endmodule
